// File: rtl/pattern_loader_if.sv
// Host-side byte port of the pattern loader: load stream in, readback stream out.
interface pattern_loader_if #(
    parameter int unsigned BITS = 8
) ();
    logic [BITS-1:0] wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic [BITS-1:0] rd_data;
    logic            rd_valid;

    // Host drives the load stream and consumes readback.
    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready,
        input  rd_data,
        input  rd_valid
    );

    // Loader consumes the load stream and produces readback.
    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/pattern_loader.sv
// Serial-side driver for the pattern buffer. Accepts BUFFERSIZE+1 bytes and shifts each
// MSB-first onto ssel/sin, capturing the old buffer contents from sout on the same edges.
module pattern_loader #(
    parameter int unsigned BUFFERSIZE = 26,
    parameter int unsigned BITS       = 8
) (
    input  logic            i_sclk,
    input  logic            i_reset,
    input  logic            i_start,
    pattern_loader_if.slave bus_if,
    output logic            o_ssel,
    output logic            o_sin,
    input  logic            i_sout,
    output logic            o_busy,
    output logic            o_done
);

    localparam int unsigned BYTE_W = (BUFFERSIZE > 0) ? $clog2(BUFFERSIZE + 1) : 1;
    localparam int unsigned BIT_W  = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [BYTE_W-1:0] r_byte_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [BITS-1:0]   r_tx_sh;
    logic [BITS-1:0]   r_rx_sh;
    logic [BITS-1:0]   r_rd_data;
    logic              r_rd_valid;

    logic [BITS-1:0]   w_rx_next;
    logic              w_last_bit;
    logic              w_last_byte;

    // sout is the buffer's pre-shift MSB, so it is captured on the very edge the buffer shifts.
    assign w_rx_next   = {r_rx_sh[BITS-2:0], i_sout};
    assign w_last_bit  = (r_bit_cnt == BIT_W'(BITS - 1));
    assign w_last_byte = (r_byte_cnt == BYTE_W'(BUFFERSIZE));

    // Outputs are decoded straight from the state so ssel maps one-to-one onto buffer shifts.
    always_comb begin
        bus_if.wr_ready = (r_state == ST_FETCH);
        bus_if.rd_data  = r_rd_data;
        bus_if.rd_valid = r_rd_valid;
        o_ssel          = (r_state == ST_SHIFT);
        o_sin           = (r_state == ST_SHIFT) ? r_tx_sh[BITS-1] : 1'b0;
        o_busy          = (r_state != ST_IDLE);
        o_done          = (r_state == ST_DONE);
    end

    // Load sequencer: fetch a byte, shift it out bit by bit, repeat until the last byte.
    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_byte_cnt <= '0;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (bus_if.wr_valid) begin
                        r_tx_sh   <= bus_if.wr_data;
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_tx_sh <= r_tx_sh << 1;
                    r_rx_sh <= w_rx_next;
                    if (w_last_bit) begin
                        r_rd_data  <= w_rx_next;
                        r_rd_valid <= 1'b1;
                        if (w_last_byte) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
                            r_state    <= ST_FETCH;
                        end
                    end else begin
                        // Held at BITS-1 on the last bit so the counter never wraps.
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: drives directed loads into a pattern buffer model and checks
// readback bytes through a scoreboard queue, plus cycle/shift counts and final contents.
module tb_pattern_loader;

    localparam int unsigned NB = 27;

    logic clk;
    logic reset;
    logic start;
    logic ssel;
    logic sin;
    logic sout;
    logic busy;
    logic done;

    int checks;
    int errors;
    int n_rd;

    logic [7:0] exp_q[$];

    // Pattern buffer model: pattern[i] = buf_q[i*8 +: 8]; shifts toward pattern[26].
    logic [NB*8-1:0] buf_q;
    logic            preload_req;
    logic [7:0]      preload_base;

    pattern_loader_if #(.BITS(8)) u_if ();

    pattern_loader #(
        .BUFFERSIZE(26),
        .BITS      (8)
    ) u_dut (
        .i_sclk (clk),
        .i_reset(reset),
        .i_start(start),
        .bus_if (u_if.slave),
        .o_ssel (ssel),
        .o_sin  (sin),
        .i_sout (sout),
        .o_busy (busy),
        .o_done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sout = buf_q[NB*8-1];

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < NB; i++) buf_q[i*8 +: 8] <= preload_base + 8'(i);
        end else if (ssel) begin
            buf_q <= {buf_q[NB*8-2:0], sin};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Readback monitor: every rd_valid pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (u_if.rd_valid === 1'b1) begin
            n_rd++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_extra actual=0x%0h required=none", u_if.rd_data);
            end else begin
                check("rd_data", 32'(u_if.rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic preload(input logic [7:0] base);
        preload_base = base;
        preload_req  = 1'b1;
        @(posedge clk);
        #1;
        preload_req = 1'b0;
    endtask

    // One load: start pulse in cycle 0, bytes base+step*k; optional FETCH stall before
    // stall_byte, extra start pulse at cycle start_at, reset at cycle abort_at.
    task automatic run_load(input logic [7:0] d_base, input logic [7:0] d_step,
                            input int stall_byte, input int stall_len,
                            input int start_at, input int abort_at,
                            output int n_cyc, output int n_ssel, output int n_done);
        int idx;
        int stall_left;
        int done_at;
        idx        = 0;
        stall_left = stall_len;
        done_at    = 0;
        n_cyc      = 0;
        n_ssel     = 0;
        n_done     = 0;
        start          = 1'b1;
        u_if.wr_valid  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            start         = (c == start_at);
            reset         = (c == abort_at);
            u_if.wr_data  = d_base + d_step * 8'(idx);
            u_if.wr_valid = (idx < NB) && !(idx == stall_byte && stall_left > 0);
            @(negedge clk);
            if (busy && !done) n_cyc++;
            if (ssel) n_ssel++;
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = c;
            end
            if (c == abort_at) check("abort_in_shift", 32'(ssel), 32'd1);
            if (c == abort_at + 1) check("abort_next_idle", 32'({ssel, busy}), 32'd0);
            if (u_if.wr_ready) begin
                if (u_if.wr_valid) idx++;
                else if (idx == stall_byte && stall_left > 0) stall_left--;
            end
            @(posedge clk);
            #1;
            if (done_at != 0 && c >= done_at + 10) break;
            if (abort_at > 0 && c >= abort_at + 20) break;
        end
        reset         = 1'b0;
        start         = 1'b0;
        u_if.wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nss;
        int ndn;
        int rd0;
        checks        = 0;
        errors        = 0;
        n_rd          = 0;
        preload_req   = 1'b0;
        preload_base  = 8'h00;
        reset         = 1'b1;
        start         = 1'b1;
        u_if.wr_valid = 1'b1;
        u_if.wr_data  = 8'h5A;

        // Reset held with start high: reset wins, everything quiet.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_outs", 32'({u_if.wr_ready, ssel, sin, u_if.rd_valid, busy, done}), 32'd0);
            check("rst_rd_data", 32'(u_if.rd_data), 32'd0);
        end
        @(posedge clk);
        #1;
        reset         = 1'b0;
        start         = 1'b0;
        u_if.wr_valid = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 32'({busy, ssel, u_if.wr_ready}), 32'd0);
        @(posedge clk);
        #1;

        // Full load 0x00..0x1A over a buffer preloaded with 0x30+i.
        preload(8'h30);
        for (int k = 0; k < NB; k++) exp_q.push_back(8'h30 + 8'(26 - k));
        rd0 = n_rd;
        run_load(8'h00, 8'h01, -1, 0, -1, -1, cyc, nss, ndn);
        check("full_done_cnt", 32'(ndn), 32'd1);
        check("full_cycles", 32'(cyc), 32'd243);
        check("full_ssel", 32'(nss), 32'd216);
        check("full_rd_cnt", 32'(n_rd - rd0), 32'd27);
        check("full_p26", 32'(buf_q[26*8 +: 8]), 32'h00);
        check("full_p0", 32'(buf_q[0 +: 8]), 32'h1A);
        for (int i = 0; i < NB; i++) check("full_pattern", 32'(buf_q[i*8 +: 8]), 32'(26 - i));

        // Readback: old contents 0xA0+i come back as 0xBA down to 0xA0.
        preload(8'hA0);
        for (int k = 0; k < NB; k++) exp_q.push_back(8'hBA - 8'(k));
        rd0 = n_rd;
        run_load(8'hFF, 8'h00, -1, 0, -1, -1, cyc, nss, ndn);
        check("rb_done_cnt", 32'(ndn), 32'd1);
        check("rb_rd_cnt", 32'(n_rd - rd0), 32'd27);
        for (int i = 0; i < NB; i++) check("rb_pattern", 32'(buf_q[i*8 +: 8]), 32'hFF);

        // Stall five FETCH cycles before byte 3; buffer was all 0xFF.
        for (int k = 0; k < NB; k++) exp_q.push_back(8'hFF);
        rd0 = n_rd;
        run_load(8'h00, 8'h01, 3, 5, -1, -1, cyc, nss, ndn);
        check("stall_done_cnt", 32'(ndn), 32'd1);
        check("stall_cycles", 32'(cyc), 32'd248);
        check("stall_ssel", 32'(nss), 32'd216);
        check("stall_rd_cnt", 32'(n_rd - rd0), 32'd27);
        for (int i = 0; i < NB; i++) check("stall_pattern", 32'(buf_q[i*8 +: 8]), 32'(26 - i));

        // Start pulse at cycle 50 is ignored; buffer currently holds pattern[i]=26-i.
        for (int k = 0; k < NB; k++) exp_q.push_back(8'(k));
        rd0 = n_rd;
        run_load(8'h40, 8'h02, -1, 0, 50, -1, cyc, nss, ndn);
        check("ign_done_cnt", 32'(ndn), 32'd1);
        check("ign_cycles", 32'(cyc), 32'd243);
        check("ign_ssel", 32'(nss), 32'd216);
        check("ign_rd_cnt", 32'(n_rd - rd0), 32'd27);
        check("ign_p26", 32'(buf_q[26*8 +: 8]), 32'h40);
        check("ign_p0", 32'(buf_q[0 +: 8]), 32'h74);

        // Abort at bit 4 of byte 10 (cycle 96): ten readback bytes, no done.
        preload(8'hC0);
        for (int k = 0; k < NB; k++) exp_q.push_back(8'hC0 + 8'(26 - k));
        rd0 = n_rd;
        run_load(8'h00, 8'h01, -1, 0, -1, 96, cyc, nss, ndn);
        check("abort_done_cnt", 32'(ndn), 32'd0);
        check("abort_rd_cnt", 32'(n_rd - rd0), 32'd10);
        check("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();

        // Clean reload after the abort; readback is whatever the buffer was left holding.
        for (int k = 0; k < NB; k++) exp_q.push_back(buf_q[(26 - k)*8 +: 8]);
        rd0 = n_rd;
        run_load(8'h00, 8'h01, -1, 0, -1, -1, cyc, nss, ndn);
        check("reload_done_cnt", 32'(ndn), 32'd1);
        check("reload_cycles", 32'(cyc), 32'd243);
        check("reload_ssel", 32'(nss), 32'd216);
        check("reload_rd_cnt", 32'(n_rd - rd0), 32'd27);
        for (int i = 0; i < NB; i++) check("reload_pattern", 32'(buf_q[i*8 +: 8]), 32'(26 - i));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
